// File: rtl/pusch_bit_interleaver_hs.sv
// pusch_bit_interleaver_hs: PUSCH rate-matching bit interleaver.
// Buffers E bits e[n], then emits f[k*Qm+j] = e[j*H+k] with H = E/Qm.
// Serial valid/ready input, back-pressured serial output.
// Optional macro INTERLEAVER_DEINT_EN adds the mode port (1 = de-interleave).

module pusch_bit_interleaver_hs #(
    parameter int  E_MAX = 94000,
    localparam int EW    = $clog2(E_MAX + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [EW-1:0] E,
    input  logic [3:0]    Qm,
`ifdef INTERLEAVER_DEINT_EN
    input  logic          mode,
`endif
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          data_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          data_out,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic          err_cfg
);

    localparam logic [EW-1:0] C_EMAX = EW'(E_MAX);
    localparam logic [EW-1:0] C_EW   = EW'(EW);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FILL, S_DRAIN} state_t;

    state_t        r_state;
    logic [EW-1:0] r_E, r_H, r_rem, r_quo, r_cnt;
    logic [EW-1:0] r_lin, r_j, r_k, r_acc;
    logic [3:0]    r_Qm;
    logic          r_in_ready, r_out_valid, r_data_out, r_out_last;
    logic          r_busy, r_done, r_err_cfg;
`ifdef INTERLEAVER_DEINT_EN
    logic          r_mode;
`endif

    logic          mem [0:E_MAX-1];

    logic          w_div_ok, w_cfg_ok, w_rem_ge, w_j_last, w_wr, w_issue;
    logic [EW-1:0] w_qm_ext, w_rem_nxt, w_waddr, w_raddr;
    logic [EW:0]   w_rem_sh;
    logic [EW-1:0] w_j_nxt, w_k_nxt, w_acc_nxt;

    // Configuration legality: Qm in {1,2,4,6,8}, E divisible by Qm, 0 < E <= E_MAX
    always_comb begin
        w_div_ok = 1'b0;
        case (Qm)
            4'd1:    w_div_ok = 1'b1;
            4'd2:    w_div_ok = ~E[0];
            4'd4:    w_div_ok = (E[1:0] == 2'b00);
            4'd6:    w_div_ok = ~E[0] && ((E % EW'(3)) == '0);
            4'd8:    w_div_ok = (E[2:0] == 3'b000);
            default: w_div_ok = 1'b0;
        endcase
    end

    assign w_cfg_ok = w_div_ok && (E != '0) && (E <= C_EMAX);

    // Restoring divider step: shift in next dividend bit, subtract Qm when it fits
    assign w_qm_ext  = {{(EW-4){1'b0}}, r_Qm};
    assign w_rem_sh  = {r_rem, r_quo[EW-1]};
    assign w_rem_ge  = (w_rem_sh >= {1'b0, w_qm_ext});
    assign w_rem_nxt = EW'(w_rem_ge ? (w_rem_sh - {1'b0, w_qm_ext}) : w_rem_sh);

    // Interleaved address walk: raddr += H along j, restart at k+1 when j wraps
    assign w_j_last = (r_j == (w_qm_ext - EW'(1)));
    always_comb begin
        w_j_nxt   = r_j + EW'(1);
        w_k_nxt   = r_k;
        w_acc_nxt = r_acc + r_H;
        if (w_j_last) begin
            w_j_nxt   = '0;
            w_k_nxt   = r_k + EW'(1);
            w_acc_nxt = r_k + EW'(1);
        end
    end

    assign w_wr    = (r_state == S_FILL) && in_valid && r_in_ready;
    assign w_issue = (r_state == S_DRAIN) && (!r_out_valid || out_ready) && (r_lin != r_E);

`ifdef INTERLEAVER_DEINT_EN
    assign w_waddr = r_mode ? r_acc : r_lin;
    assign w_raddr = r_mode ? r_lin : r_acc;
`else
    assign w_waddr = r_lin;
    assign w_raddr = r_acc;
`endif

    // Codeword storage; not cleared by reset
    always_ff @(posedge clk) begin
        if (w_wr) mem[w_waddr] <= data_in;
    end

    // Control FSM with registered handshake and status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_E         <= '0;
            r_H         <= '0;
            r_Qm        <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_cnt       <= '0;
            r_lin       <= '0;
            r_j         <= '0;
            r_k         <= '0;
            r_acc       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_data_out  <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_cfg   <= 1'b0;
`ifdef INTERLEAVER_DEINT_EN
            r_mode      <= 1'b0;
`endif
        end else begin
            r_done    <= 1'b0;
            r_err_cfg <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_E  <= E;
                        r_Qm <= Qm;
`ifdef INTERLEAVER_DEINT_EN
                        r_mode <= mode;
`endif
                        if (w_cfg_ok) begin
                            r_state <= S_CALC;
                            r_busy  <= 1'b1;
                            r_rem   <= '0;
                            r_quo   <= E;
                            r_cnt   <= '0;
                            r_lin   <= '0;
                            r_j     <= '0;
                            r_k     <= '0;
                            r_acc   <= '0;
                        end else begin
                            r_err_cfg <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    // EW divider steps, then one cycle to move the quotient into H
                    if (r_cnt != C_EW) begin
                        r_rem <= w_rem_nxt;
                        r_quo <= {r_quo[EW-2:0], w_rem_ge};
                        r_cnt <= r_cnt + EW'(1);
                    end else begin
                        r_H        <= r_quo;
                        r_state    <= S_FILL;
                        r_in_ready <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (w_wr) begin
                        r_lin <= r_lin + EW'(1);
`ifdef INTERLEAVER_DEINT_EN
                        if (r_mode) begin
                            r_j   <= w_j_nxt;
                            r_k   <= w_k_nxt;
                            r_acc <= w_acc_nxt;
                        end
`endif
                        if (r_lin == r_E - EW'(1)) r_in_ready <= 1'b0;
                    end else if (!r_in_ready) begin
                        // Counters are reused by the read side
                        r_state <= S_DRAIN;
                        r_lin   <= '0;
                        r_j     <= '0;
                        r_k     <= '0;
                        r_acc   <= '0;
                    end
                end
                S_DRAIN: begin
                    if (w_issue) begin
                        r_data_out  <= mem[w_raddr];
                        r_out_valid <= 1'b1;
                        r_out_last  <= (r_lin == r_E - EW'(1));
                        r_lin       <= r_lin + EW'(1);
`ifdef INTERLEAVER_DEINT_EN
                        if (!r_mode) begin
                            r_j   <= w_j_nxt;
                            r_k   <= w_k_nxt;
                            r_acc <= w_acc_nxt;
                        end
`else
                        r_j   <= w_j_nxt;
                        r_k   <= w_k_nxt;
                        r_acc <= w_acc_nxt;
`endif
                    end else if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (r_out_last) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign data_out  = r_data_out;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err_cfg   = r_err_cfg;

endmodule
